muxn_toggle_monitor: RTL and testbench

MUXN_TOGGLE_MONITOR -- requirements
Module: muxn_toggle_monitor

---
 rtl/muxn_toggle_monitor.sv | 127 ++++++++++++
 tb/tb_muxn_toggle_monitor.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muxn_toggle_monitor.sv
// Registered N-way mux that also measures output bit activity: the number of
// out bits that flip, summed (saturating) over windows of WIN accepted samples.
module muxn_toggle_monitor #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N),
  parameter int WIN   = 16,
  parameter int CNTW  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_bus,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  input  logic               clear,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  output logic [CNTW-1:0]    toggle_count,
  output logic               win_done
);

  localparam int PCW  = $clog2(WIDTH + 1);
  localparam int SUMW = ((CNTW > PCW) ? CNTW : PCW) + 1;
  localparam int WCW  = (WIN > 1) ? $clog2(WIN) : 1;

  localparam logic [WCW-1:0]  WIN_LAST = WCW'(WIN - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
  localparam logic [SUMW-1:0] SUM_MAX  = {{(SUMW - CNTW){1'b0}}, {CNTW{1'b1}}};

  logic [WIDTH-1:0] chan [N];
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] diff;
  logic [PCW-1:0]   pc;
  logic [SUMW-1:0]  sum;
  logic [CNTW-1:0]  sat_sum;

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [CNTW-1:0]  acc_q, acc_d;
  logic [WCW-1:0]   win_cnt_q, win_cnt_d;
  logic [CNTW-1:0]  toggle_count_q, toggle_count_d;
  logic             win_done_q, win_done_d;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign chan[gi] = in_bus[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Selects that match no channel fall through to all-zeros.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        sel_data = chan[k];
      end
    end
  end

  always_comb begin
    diff = sel_data ^ out_q;
    pc   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + PCW'(diff[i]);
    end
  end

  // One spare bit of headroom lets the clamp see an overflow instead of a wrap.
  always_comb begin
    sum     = SUMW'(acc_q) + SUMW'(pc);
    sat_sum = (sum > SUM_MAX) ? CNT_MAX : sum[CNTW-1:0];
  end

  always_comb begin
    out_d          = out_q;
    out_valid_d    = in_valid;
    acc_d          = acc_q;
    win_cnt_d      = win_cnt_q;
    toggle_count_d = toggle_count_q;
    win_done_d     = 1'b0;

    if (in_valid) begin
      out_d = sel_data;
    end

    // A sample arriving together with clear still moves out but is not counted.
    if (clear) begin
      acc_d     = '0;
      win_cnt_d = '0;
    end else if (in_valid) begin
      if (win_cnt_q == WIN_LAST) begin
        toggle_count_d = sat_sum;
        acc_d          = '0;
        win_cnt_d      = '0;
        win_done_d     = 1'b1;
      end else begin
        acc_d     = sat_sum;
        win_cnt_d = win_cnt_q + WCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q          <= '0;
      out_valid_q    <= 1'b0;
      acc_q          <= '0;
      win_cnt_q      <= '0;
      toggle_count_q <= '0;
      win_done_q     <= 1'b0;
    end else begin
      out_q          <= out_d;
      out_valid_q    <= out_valid_d;
      acc_q          <= acc_d;
      win_cnt_q      <= win_cnt_d;
      toggle_count_q <= toggle_count_d;
      win_done_q     <= win_done_d;
    end
  end

  assign out          = out_q;
  assign out_valid    = out_valid_q;
  assign toggle_count = toggle_count_q;
  assign win_done     = win_done_q;

endmodule

// File: tb/tb_muxn_toggle_monitor.sv
// Bench for muxn_toggle_monitor: two parameterisations share one stimulus stream
// and are compared against a sample-level reference model.
module tb_muxn_toggle_monitor;

  localparam int WIN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus;
  logic [1:0]  sel;
  logic        in_valid;
  logic        clear;

  logic [7:0]  out_a, out_b;
  logic        ov_a, ov_b;
  logic [15:0] tc_a;
  logic [3:0]  tc_b;
  logic        wd_a, wd_b;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state, index 0 = dut_a (N=4, CNTW=16), 1 = dut_b (N=3, CNTW=4)
  logic [7:0]  exp_out  [2];
  logic        exp_ov   [2];
  logic [15:0] exp_tc   [2];
  logic        exp_done [2];
  int          m_acc    [2];
  int          m_cnt    [2];

  logic [7:0]  obs_out  [2];
  logic        obs_ov   [2];
  logic [15:0] obs_tc   [2];
  logic        obs_done [2];

  assign obs_out[0]  = out_a;
  assign obs_out[1]  = out_b;
  assign obs_ov[0]   = ov_a;
  assign obs_ov[1]   = ov_b;
  assign obs_tc[0]   = tc_a;
  assign obs_tc[1]   = {12'h000, tc_b};
  assign obs_done[0] = wd_a;
  assign obs_done[1] = wd_b;

  always #5 clk = ~clk;

  muxn_toggle_monitor #(.WIDTH(8), .N(4), .WIN(WIN), .CNTW(16)) dut_a (
    .clk(clk), .rst(rst), .in_bus(bus), .sel(sel), .in_valid(in_valid), .clear(clear),
    .out(out_a), .out_valid(ov_a), .toggle_count(tc_a), .win_done(wd_a)
  );

  muxn_toggle_monitor #(.WIDTH(8), .N(3), .WIN(WIN), .CNTW(4)) dut_b (
    .clk(clk), .rst(rst), .in_bus(bus[23:0]), .sel(sel), .in_valid(in_valid), .clear(clear),
    .out(out_b), .out_valid(ov_b), .toggle_count(tc_b), .win_done(wd_b)
  );

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_out[d]  = 8'h00;
      exp_ov[d]   = 1'b0;
      exp_tc[d]   = 16'h0000;
      exp_done[d] = 1'b0;
      m_acc[d]    = 0;
      m_cnt[d]    = 0;
    end
  endtask

  // Window rules applied per accepted sample with integer arithmetic.
  task automatic model_edge();
    logic [7:0] nv;
    int pc, tot, nch, maxv;
    for (int d = 0; d < 2; d++) begin
      nch  = (d == 0) ? 4 : 3;
      maxv = (d == 0) ? 65535 : 15;
      nv   = (int'(sel) < nch) ? 8'(bus >> (8 * int'(sel))) : 8'h00;
      pc   = $countones(nv ^ exp_out[d]);
      if (clear) begin
        m_acc[d] = 0;
        m_cnt[d] = 0;
        exp_done[d] = 1'b0;
      end else if (in_valid) begin
        m_cnt[d] = m_cnt[d] + 1;
        tot = m_acc[d] + pc;
        if (tot > maxv) tot = maxv;
        if (m_cnt[d] == WIN) begin
          exp_tc[d]   = 16'(tot);
          m_acc[d]    = 0;
          m_cnt[d]    = 0;
          exp_done[d] = 1'b1;
        end else begin
          m_acc[d]    = tot;
          exp_done[d] = 1'b0;
        end
      end else begin
        exp_done[d] = 1'b0;
      end
      if (in_valid) exp_out[d] = nv;
      exp_ov[d] = in_valid;
    end
  endtask

  task automatic step(input logic v, input logic [1:0] s, input logic [31:0] b, input logic c);
    in_valid = v;
    sel      = s;
    bus      = b;
    clear    = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clear    = 1'b0;
    rst      = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; sel = 2'd0; bus = 32'h0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks_total++;
      if (obs_out[d] !== 8'h00) $display("FAIL reset_out dut%0d: got %h expected 00", d, obs_out[d]);
      else checks_passed++;
      checks_total++;
      if (obs_ov[d] !== 1'b0) $display("FAIL reset_out_valid dut%0d: got %b expected 0", d, obs_ov[d]);
      else checks_passed++;
      checks_total++;
      if (obs_tc[d] !== 16'h0) $display("FAIL reset_toggle_count dut%0d: got %0d expected 0", d, obs_tc[d]);
      else checks_passed++;
      checks_total++;
      if (obs_done[d] !== 1'b0) $display("FAIL reset_win_done dut%0d: got %b expected 0", d, obs_done[d]);
      else checks_passed++;
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic test_select();
    step(1'b1, 2'd2, 32'h44332211, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks_total++;
      if (obs_out[d] !== 8'h33 || obs_ov[d] !== 1'b1)
        $display("FAIL select_load dut%0d: got out=%h ov=%b expected out=33 ov=1", d, obs_out[d], obs_ov[d]);
      else checks_passed++;
    end
    step(1'b0, 2'd0, 32'h44332211, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks_total++;
      if (obs_out[d] !== 8'h33 || obs_ov[d] !== 1'b0)
        $display("FAIL select_hold dut%0d: got out=%h ov=%b expected out=33 ov=0", d, obs_out[d], obs_ov[d]);
      else checks_passed++;
    end
  endtask

  task automatic test_window();
    logic [1:0] pat [4];
    pat = '{2'd1, 2'd0, 2'd1, 2'd0};
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pat[i], 32'h0000FF00, 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks_total++;
        if (obs_done[d] !== (i == 3))
          $display("FAIL window_done dut%0d sample%0d: got %b expected %b", d, i, obs_done[d], (i == 3));
        else checks_passed++;
      end
    end
    checks_total++;
    if (tc_a !== 16'd32) $display("FAIL window_count dut0: got %0d expected 32", tc_a);
    else checks_passed++;
    checks_total++;
    if (tc_b !== 4'd15) $display("FAIL window_saturate dut1: got %0d expected 15", tc_b);
    else checks_passed++;
    step(1'b0, 2'd1, 32'h0000FF00, 1'b0);
    checks_total++;
    if (wd_a !== 1'b0 || wd_b !== 1'b0 || tc_a !== 16'd32)
      $display("FAIL window_pulse_end: got done=%b/%b tc=%0d expected done=0/0 tc=32", wd_a, wd_b, tc_a);
    else checks_passed++;
  endtask

  task automatic test_out_of_range();
    do_reset();
    step(1'b1, 2'd0, 32'h000000AA, 1'b0);
    step(1'b1, 2'd3, 32'h000000AA, 1'b0);
    checks_total++;
    if (out_b !== 8'h00) $display("FAIL oor_out dut1: got %h expected 00", out_b);
    else checks_passed++;
    step(1'b1, 2'd3, 32'h000000AA, 1'b0);
    step(1'b1, 2'd3, 32'h000000AA, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks_total++;
      if (obs_tc[d] !== 16'd8 || obs_done[d] !== 1'b1)
        $display("FAIL oor_count dut%0d: got tc=%0d done=%b expected tc=8 done=1", d, obs_tc[d], obs_done[d]);
      else checks_passed++;
    end
  endtask

  task automatic test_clear();
    logic [1:0] pat [4];
    pat = '{2'd0, 2'd1, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, pat[3-i], 32'h0000FF00, 1'b0);
    step(1'b1, 2'd1, 32'h0000FF00, 1'b0);
    step(1'b1, 2'd0, 32'h0000FF00, 1'b0);
    step(1'b1, 2'd1, 32'h0000FF00, 1'b1);
    checks_total++;
    if (out_a !== 8'hFF || wd_a !== 1'b0 || wd_b !== 1'b0 || tc_a !== 16'd32 || tc_b !== 4'd15)
      $display("FAIL clear_same_edge: got out=%h done=%b/%b tc=%0d/%0d expected out=ff done=0/0 tc=32/15",
               out_a, wd_a, wd_b, tc_a, tc_b);
    else checks_passed++;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pat[i], 32'h00000F00, 1'b0);
      checks_total++;
      if (wd_a !== (i == 3) || wd_b !== (i == 3))
        $display("FAIL clear_window_done sample%0d: got %b/%b expected %b", i, wd_a, wd_b, (i == 3));
      else checks_passed++;
    end
    checks_total++;
    if (tc_a !== 16'd20 || tc_b !== 4'd15)
      $display("FAIL clear_window_count: got %0d/%0d expected 20/15", tc_a, tc_b);
    else checks_passed++;
  endtask

  task automatic test_async_reset();
    logic [1:0] pat [4];
    pat = '{2'd1, 2'd0, 2'd1, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, pat[i], 32'h0000FF00, 1'b0);
    step(1'b1, 2'd1, 32'h0000FF00, 1'b0);
    step(1'b1, 2'd0, 32'h0000FF00, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks_total++;
      if (obs_out[d] !== 8'h00 || obs_ov[d] !== 1'b0 || obs_tc[d] !== 16'h0 || obs_done[d] !== 1'b0)
        $display("FAIL async_reset dut%0d: got out=%h ov=%b tc=%0d done=%b expected all 0",
                 d, obs_out[d], obs_ov[d], obs_tc[d], obs_done[d]);
      else checks_passed++;
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pat[i], 32'h0000FF00, 1'b0);
      checks_total++;
      if (wd_a !== (i == 3) || wd_b !== (i == 3))
        $display("FAIL post_reset_done sample%0d: got %b/%b expected %b", i, wd_a, wd_b, (i == 3));
      else checks_passed++;
    end
    checks_total++;
    if (tc_a !== 16'd32) $display("FAIL post_reset_count: got %0d expected 32", tc_a);
    else checks_passed++;
  endtask

  task automatic test_random();
    logic        v, c;
    logic [1:0]  s;
    logic [31:0] b;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      s = 2'($urandom);
      b = $urandom;
      step(v, s, b, c);
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        rst = 1'b0;
      end
      $display("txn %0d v=%0b sel=%0d bus=%h clr=%0b out=%h/%h tc=%0d/%0d done=%0b/%0b",
               n, v, s, b, c, out_a, out_b, tc_a, tc_b, wd_a, wd_b);
      for (int d = 0; d < 2; d++) begin
        checks_total++;
        if (obs_out[d] !== exp_out[d]) $display("FAIL rnd_out dut%0d txn%0d: got %h expected %h", d, n, obs_out[d], exp_out[d]);
        else checks_passed++;
        checks_total++;
        if (obs_ov[d] !== exp_ov[d]) $display("FAIL rnd_out_valid dut%0d txn%0d: got %b expected %b", d, n, obs_ov[d], exp_ov[d]);
        else checks_passed++;
        checks_total++;
        if (obs_tc[d] !== exp_tc[d]) $display("FAIL rnd_toggle_count dut%0d txn%0d: got %0d expected %0d", d, n, obs_tc[d], exp_tc[d]);
        else checks_passed++;
        checks_total++;
        if (obs_done[d] !== exp_done[d]) $display("FAIL rnd_win_done dut%0d txn%0d: got %b expected %b", d, n, obs_done[d], exp_done[d]);
        else checks_passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_window();
    test_out_of_range();
    test_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
